sram_axi_bridge: RTL and testbench
==================================

# sram_axi_bridge

Converts the two sram-like memory ports, instruction fetch and data cache (`cache_data_*`), into a single AXI3 master. It sits directly downstream of the write-back data cache and the instruction path, and upstream of the SoC AXI interconnect. It runs one blocking, single-beat transaction at a time. Data requests have fixed priority over instruction requests.

## Interface
- `INST_ID`, default 4'd0: AXI ID used for instruction transactions.
- `DATA_ID`, default 4'd1: AXI ID used for data transactions.

Ports (name, direction, width, meaning):
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `inst_req`, `inst_wr` in 1/1: instruction request and write flag (`inst_wr` is tied 0 by the core).
- `inst_size`, `inst_addr`, `inst_wdata` in 2/32/32: sram-like request fields.
- `inst_rdata`, `inst_addr_ok`, `inst_data_ok` out 32/1/1: read data and the two handshake pulses.
- `data_req`, `data_wr`, `data_size`, `data_addr`, `data_wdata` in 1/1/2/32/32: driven by the data cache `cache_data_*` outputs.
- `data_rdata`, `data_addr_ok`, `data_data_ok` out 32/1/1: to the data cache `cache_data_*` inputs.
- `arid`, `araddr`, `arsize` out 4/32/3: read address channel.
- `arlen`, `arburst`, `arlock`, `arcache`, `arprot` out 4/2/2/4/3: constants 0 / 2'b01 / 0 / 0 / 0.
- `arvalid` out 1, `arready` in 1.
- `rid` in 4, `rdata` in 32, `rresp` in 2, `rlast` in 1, `rvalid` in 1, `rready` out 1.
- `awid`, `awaddr`, `awsize` out 4/32/3; `awlen`, `awburst`, `awlock`, `awcache`, `awprot` are the same constants as the AR channel.
- `awvalid` out 1, `awready` in 1.
- `wid` out 4, `wdata` out 32, `wstrb` out 4, `wlast` out 1 (constant 1), `wvalid` out 1, `wready` in 1.
- `bid` in 4, `bresp` in 2, `bvalid` in 1, `bready` out 1.

## Operation
States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP.

**IDLE**
- If `data_req` is high: assert `data_addr_ok`. Latch owner=data, wr, size, addr, wdata.
- Else if `inst_req` is high: assert `inst_addr_ok` and latch the inst fields the same way.
- Next state is RD_ADDR if wr=0, WR_REQ if wr=1.

**RD_ADDR**
- `arvalid`=1; `araddr`=latched addr; `arsize`={1'b0,size}; `arid`=owner ID.
- On `arvalid & arready`, go to RD_DATA.

**RD_DATA**
- `rready`=1.
- On `rvalid`, pulse the owner's `*_data_ok` that same cycle, with `*_rdata`=`rdata` combinationally. Go to IDLE.
- `rresp` and `rid` are ignored.

**WR_REQ**
- `awvalid` and `wvalid` rise together. Each drops independently once its handshake completes: `aw_done` and `w_done` flags, cleared on entry.
- `wstrb` is computed from size and addr[1:0]:
  - byte: 0001 << addr[1:0]
  - half: 0011 when addr[1]=0, 1100 when addr[1]=1
  - word: 1111
- `wdata`=latched wdata.
- Go to WR_RESP once both handshakes are done; they may complete in the same cycle.

**WR_RESP**
- `bready`=1.
- On `bvalid`, pulse the owner's `*_data_ok` and go to IDLE.

General rules:
- Unlatched `*_rdata` outputs are don't-care; drive them with `rdata`.
- The non-owner's handshakes stay 0 for the whole transaction.
- Instructions waiting behind continuous data traffic may starve. This is acceptable.

## Timing
- Reset: state=IDLE, every valid/ready/ok output is 0, flags are cleared.
- `addr_ok` is combinational in the same cycle as `req` while in IDLE. There is no `addr_ok` outside IDLE.
- Best-case read (`arready` and `rvalid` held high): req@0 and addr_ok@0, arvalid@1, data_ok@2, next addr_ok@3.
- Best-case write: req@0, aw/wvalid@1, data_ok@2.
- `araddr`/`awaddr` and the other payloads are stable while the corresponding valid is high.
- A valid never drops before its handshake completes.
- Reset mid-transaction: the next edge forces IDLE and deasserts all valids. The interconnect is reset by the same `rst`.
- Simultaneous `inst_req` and `data_req` in IDLE: data wins and `inst_addr_ok`=0. The inst port keeps `req` asserted and is served next.

## Structure
- Package `axi_bridge_pkg`: state enum and AXI constants (`BURST_INCR`=2'b01, `LEN_SINGLE`=0, `CACHE_NONE`, `PROT_NONE`).
- Sub-module `sram_wstrb_gen`: combinational size/addr[1:0] to `wstrb`. It is shared with the data cache write-mask logic.

## Test plan
1. Data read at 0x1FC0_0004, `arready` stalls 3 cycles, `rdata`=0xDEADBEEF after 2 more cycles → `araddr`=0x1FC00004, `arsize`=3'b010, `arid`=1, `data_data_ok` for exactly one cycle with `data_rdata`=0xDEADBEEF.
2. Byte store, size=00, addr 0x...3, wdata 0x000000AB → `wstrb`=1000. With `awready` at cycle 1 and `wready` at cycle 4: `awvalid` drops at 2, `wvalid` drops at 5, `bready` is seen, `data_data_ok` follows `bvalid`.
3. `inst_req` and `data_req` both high in IDLE → `data_addr_ok`=1 and `inst_addr_ok`=0. After the data `data_ok`, `inst_addr_ok` follows in the next IDLE cycle, with `arid`=0.
4. Half store at addr 0x...2 → `wstrb`=1100. AW and W accepted in the same cycle → go directly to WR_RESP.
5. `rst` asserted in RD_DATA → next cycle: IDLE, `arvalid`/`rready`/`awvalid`/`wvalid`/`bready`=0, no `data_ok`.
6. Back-to-back data-cache WM then RM (dirty miss) → write completes with `data_data_ok`, then read `addr_ok` follows one cycle later. Check order on AXI: AW/W, then B, then AR, then R.

Source files
------------

// File: rtl/sram_axi_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi_bridge_pkg
// Brief    : Shared FSM encoding and fixed AXI3 attribute values for the
//            sram-like to AXI3 bridge.
// Revision : 1.0 - initial release
// ============================================================================
package axi_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ADDR = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_WR_RESP = 3'd4
    } state_t;

    localparam logic [3:0] LEN_SINGLE  = 4'd0;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] LOCK_NORMAL = 2'b00;
    localparam logic [3:0] CACHE_NONE  = 4'd0;
    localparam logic [2:0] PROT_NONE   = 3'd0;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

endpackage
`default_nettype wire

// File: rtl/sram_axi_bridge_if.sv
`default_nettype none
// ============================================================================
// Module   : sram_axi_bridge_if
// Brief    : Single-beat AXI3 bus between the bridge (master) and the SoC
//            interconnect (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface sram_axi_bridge_if;

    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;

    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [1:0]  awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;

    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

endinterface
`default_nettype wire

// File: rtl/sram_wstrb_gen.sv
`default_nettype none
// ============================================================================
// Module   : sram_wstrb_gen
// Brief    : Byte-lane write strobe from sram-like size and low address bits.
// Revision : 1.0 - initial release
// ============================================================================
module sram_wstrb_gen
    import axi_bridge_pkg::*;
(
    input  wire logic [1:0] size,
    input  wire logic [1:0] addr_lo,
    output logic      [3:0] wstrb
);

    always_comb begin
        wstrb = 4'b1111;
        case (size)
            SIZE_BYTE: wstrb = 4'b0001 << addr_lo;
            SIZE_HALF: wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
            default:   wstrb = 4'b1111;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/sram_axi_bridge.sv
`default_nettype none
// ============================================================================
// Module   : sram_axi_bridge
// Brief    : Merges instruction and data sram-like ports into one blocking,
//            single-beat AXI3 master; data has fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
module sram_axi_bridge
    import axi_bridge_pkg::*;
#(
    parameter logic [3:0] INST_ID = 4'd0,
    parameter logic [3:0] DATA_ID = 4'd1
) (
    input  wire logic        clk,
    input  wire logic        rst,

    input  wire logic        inst_req,
    input  wire logic        inst_wr,
    input  wire logic [1:0]  inst_size,
    input  wire logic [31:0] inst_addr,
    input  wire logic [31:0] inst_wdata,
    output logic      [31:0] inst_rdata,
    output logic             inst_addr_ok,
    output logic             inst_data_ok,

    input  wire logic        data_req,
    input  wire logic        data_wr,
    input  wire logic [1:0]  data_size,
    input  wire logic [31:0] data_addr,
    input  wire logic [31:0] data_wdata,
    output logic      [31:0] data_rdata,
    output logic             data_addr_ok,
    output logic             data_data_ok,

    sram_axi_bridge_if.master axi
);

    state_t      r_state;
    state_t      w_next_state;
    logic        r_owner_data;
    logic        r_wr;
    logic [1:0]  r_size;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_aw_done;
    logic        r_w_done;

    logic        w_take;
    logic        w_aw_fire;
    logic        w_w_fire;
    logic [3:0]  w_id;
    logic [3:0]  w_wstrb;
    logic        w_unused;

    assign w_take    = (r_state == ST_IDLE) && (data_req || inst_req);
    assign w_aw_fire = (r_state == ST_WR_REQ) && !r_aw_done && axi.awready;
    assign w_w_fire  = (r_state == ST_WR_REQ) && !r_w_done  && axi.wready;
    assign w_id      = r_owner_data ? DATA_ID : INST_ID;
    assign w_unused  = ^{axi.rid, axi.rresp, axi.rlast, axi.bid, axi.bresp};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Handshake-done flags are cleared in IDLE so every write starts fresh.
    always_ff @(posedge clk) begin
        if (rst || (r_state == ST_IDLE)) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            if (w_aw_fire) r_aw_done <= 1'b1;
            if (w_w_fire)  r_w_done  <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_take) begin
            r_owner_data <= data_req;
            r_wr         <= data_req ? data_wr    : inst_wr;
            r_size       <= data_req ? data_size  : inst_size;
            r_addr       <= data_req ? data_addr  : inst_addr;
            r_wdata      <= data_req ? data_wdata : inst_wdata;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (data_req) begin
                    w_next_state = data_wr ? ST_WR_REQ : ST_RD_ADDR;
                end else if (inst_req) begin
                    w_next_state = inst_wr ? ST_WR_REQ : ST_RD_ADDR;
                end
            end
            ST_RD_ADDR: if (axi.arready) w_next_state = ST_RD_DATA;
            ST_RD_DATA: if (axi.rvalid)  w_next_state = ST_IDLE;
            ST_WR_REQ: begin
                if ((r_aw_done || w_aw_fire) && (r_w_done || w_w_fire)) begin
                    w_next_state = ST_WR_RESP;
                end
            end
            ST_WR_RESP: if (axi.bvalid) w_next_state = ST_IDLE;
            default:    w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        inst_addr_ok = 1'b0;
        data_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        data_data_ok = 1'b0;
        axi.arvalid  = 1'b0;
        axi.rready   = 1'b0;
        axi.awvalid  = 1'b0;
        axi.wvalid   = 1'b0;
        axi.bready   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                data_addr_ok = data_req;
                inst_addr_ok = inst_req && !data_req;
            end
            ST_RD_ADDR: axi.arvalid = 1'b1;
            ST_RD_DATA: begin
                axi.rready   = 1'b1;
                data_data_ok = axi.rvalid &&  r_owner_data;
                inst_data_ok = axi.rvalid && !r_owner_data;
            end
            ST_WR_REQ: begin
                axi.awvalid = !r_aw_done;
                axi.wvalid  = !r_w_done;
            end
            ST_WR_RESP: begin
                axi.bready   = 1'b1;
                data_data_ok = axi.bvalid &&  r_owner_data;
                inst_data_ok = axi.bvalid && !r_owner_data;
            end
            default: ;
        endcase
    end

    sram_wstrb_gen u_wstrb_gen (
        .size    (r_size),
        .addr_lo (r_addr[1:0]),
        .wstrb   (w_wstrb)
    );

    assign inst_rdata  = axi.rdata;
    assign data_rdata  = axi.rdata;

    assign axi.arid    = w_id;
    assign axi.araddr  = r_addr;
    assign axi.arsize  = {1'b0, r_size};
    assign axi.arlen   = LEN_SINGLE;
    assign axi.arburst = BURST_INCR;
    assign axi.arlock  = LOCK_NORMAL;
    assign axi.arcache = CACHE_NONE;
    assign axi.arprot  = PROT_NONE;

    assign axi.awid    = w_id;
    assign axi.awaddr  = r_addr;
    assign axi.awsize  = {1'b0, r_size};
    assign axi.awlen   = LEN_SINGLE;
    assign axi.awburst = BURST_INCR;
    assign axi.awlock  = LOCK_NORMAL;
    assign axi.awcache = CACHE_NONE;
    assign axi.awprot  = PROT_NONE;

    assign axi.wid     = w_id;
    assign axi.wdata   = r_wdata;
    assign axi.wstrb   = w_wstrb;
    assign axi.wlast   = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_sram_axi_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_axi_bridge
// Brief    : Directed scenarios for sram_axi_bridge with a response scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_axi_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req, inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr, inst_wdata, inst_rdata;
    logic        inst_addr_ok, inst_data_ok;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        data_addr_ok, data_data_ok;

    sram_axi_bridge_if axi_bus ();

    sram_axi_bridge #(
        .INST_ID (4'd0),
        .DATA_ID (4'd1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .inst_req     (inst_req),
        .inst_wr      (inst_wr),
        .inst_size    (inst_size),
        .inst_addr    (inst_addr),
        .inst_wdata   (inst_wdata),
        .inst_rdata   (inst_rdata),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_rdata   (data_rdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .axi          (axi_bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_data;
        bit          is_read;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] ref_wstrb(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            2'b00:   return (lo == 2'd0) ? 4'b0001 : (lo == 2'd1) ? 4'b0010 :
                            (lo == 2'd2) ? 4'b0100 : 4'b1000;
            2'b01:   return lo[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    task automatic push_exp(input bit is_data, input bit is_read, input logic [31:0] rd);
        exp_t e;
        e.is_data = is_data;
        e.is_read = is_read;
        e.rdata   = rd;
        sb_q.push_back(e);
    endtask

    // Drive a data request in IDLE and confirm it is accepted this cycle.
    task automatic issue_data(input logic wr, input logic [1:0] size,
                              input logic [31:0] addr, input logic [31:0] wdata);
        data_req   = 1'b1;
        data_wr    = wr;
        data_size  = size;
        data_addr  = addr;
        data_wdata = wdata;
        #1;
        chk("data_addr_ok", {31'b0, data_addr_ok}, 32'd1);
        chk("inst_addr_ok_blocked", {31'b0, inst_addr_ok}, 32'd0);
    endtask

    // Every *_data_ok pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst === 1'b0 && (data_data_ok === 1'b1 || inst_data_ok === 1'b1)) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_data_ok", {30'b0, data_data_ok, inst_data_ok}, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("ok_owner", {30'b0, data_data_ok, inst_data_ok},
                    mon_e.is_data ? 32'd2 : 32'd1);
                if (mon_e.is_read)
                    chk("ok_rdata", mon_e.is_data ? data_rdata : inst_rdata, mon_e.rdata);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        inst_req = 0; inst_wr = 0; inst_size = 0; inst_addr = 0; inst_wdata = 0;
        data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
        axi_bus.arready = 0; axi_bus.rvalid = 0; axi_bus.rdata = 0;
        axi_bus.rid = 0; axi_bus.rresp = 0; axi_bus.rlast = 1;
        axi_bus.awready = 0; axi_bus.wready = 0;
        axi_bus.bvalid = 0; axi_bus.bid = 0; axi_bus.bresp = 0;

        // Reset state
        repeat (2) tick();
        chk("rst_valids", {27'b0, axi_bus.arvalid, axi_bus.rready, axi_bus.awvalid,
                           axi_bus.wvalid, axi_bus.bready}, 32'd0);
        chk("rst_oks", {28'b0, data_addr_ok, data_data_ok, inst_addr_ok, inst_data_ok}, 32'd0);
        rst = 1'b0;
        tick();

        // Data read with AR stall of three cycles, R two cycles later
        push_exp(1, 1, 32'hDEADBEEF);
        issue_data(1'b0, 2'b10, 32'h1FC0_0004, 32'h0);
        tick(); data_req = 0;
        #1;
        chk("t1_arvalid", {31'b0, axi_bus.arvalid}, 32'd1);
        chk("t1_araddr", axi_bus.araddr, 32'h1FC0_0004);
        chk("t1_arsize", {29'b0, axi_bus.arsize}, 32'd2);
        chk("t1_arid", {28'b0, axi_bus.arid}, 32'd1);
        chk("t1_arlen_burst", {26'b0, axi_bus.arlen, axi_bus.arburst}, 32'd1);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("t1_arvalid_hold", {31'b0, axi_bus.arvalid}, 32'd1);
            chk("t1_araddr_hold", axi_bus.araddr, 32'h1FC0_0004);
        end
        tick(); axi_bus.arready = 1;
        tick(); axi_bus.arready = 0;
        #1;
        chk("t1_arvalid_drop", {31'b0, axi_bus.arvalid}, 32'd0);
        chk("t1_rready", {31'b0, axi_bus.rready}, 32'd1);
        tick();
        chk("t1_no_early_ok", {31'b0, data_data_ok}, 32'd0);
        tick(); axi_bus.rvalid = 1; axi_bus.rdata = 32'hDEADBEEF;
        #1;
        chk("t1_data_ok", {31'b0, data_data_ok}, 32'd1);
        tick(); axi_bus.rvalid = 0; axi_bus.rdata = 0;
        #1;
        chk("t1_data_ok_single", {31'b0, data_data_ok}, 32'd0);
        chk("t1_rready_drop", {31'b0, axi_bus.rready}, 32'd0);

        // Byte store, AW accepted at 1 and W at 4
        push_exp(1, 0, 32'h0);
        issue_data(1'b1, 2'b00, 32'h0000_1003, 32'h0000_00AB);
        tick(); data_req = 0; axi_bus.awready = 1;
        #1;
        chk("t2_valids", {30'b0, axi_bus.awvalid, axi_bus.wvalid}, 32'd3);
        chk("t2_wstrb", {28'b0, axi_bus.wstrb}, 32'h8);
        chk("t2_wdata", axi_bus.wdata, 32'h0000_00AB);
        chk("t2_awaddr", axi_bus.awaddr, 32'h0000_1003);
        chk("t2_awsize_id_last", {24'b0, axi_bus.awsize, axi_bus.awid, axi_bus.wlast}, {24'b0, 3'd0, 4'd1, 1'b1});
        tick(); axi_bus.awready = 0;
        #1;
        chk("t2_aw_drop", {30'b0, axi_bus.awvalid, axi_bus.wvalid}, 32'd1);
        tick();
        chk("t2_w_hold", {31'b0, axi_bus.wvalid}, 32'd1);
        tick(); axi_bus.wready = 1;
        #1;
        chk("t2_w_hold4", {30'b0, axi_bus.wvalid, axi_bus.bready}, 32'd2);
        tick(); axi_bus.wready = 0;
        #1;
        chk("t2_w_drop_bready", {30'b0, axi_bus.wvalid, axi_bus.bready}, 32'd1);
        tick(); axi_bus.bvalid = 1;
        #1;
        chk("t2_data_ok", {31'b0, data_data_ok}, 32'd1);
        tick(); axi_bus.bvalid = 0;
        #1;
        chk("t2_bready_drop", {31'b0, axi_bus.bready}, 32'd0);

        // Simultaneous inst and data requests: data first, then inst
        inst_req = 1; inst_wr = 0; inst_size = 2'b10; inst_addr = 32'h0000_0200;
        push_exp(1, 1, 32'h1111_1111);
        issue_data(1'b0, 2'b10, 32'h0000_0100, 32'h0);
        tick(); data_req = 0; axi_bus.arready = 1;
        #1;
        chk("t3_arid_data", {28'b0, axi_bus.arid}, 32'd1);
        chk("t3_inst_addr_ok_busy", {31'b0, inst_addr_ok}, 32'd0);
        tick(); axi_bus.arready = 0; axi_bus.rvalid = 1; axi_bus.rdata = 32'h1111_1111;
        #1;
        chk("t3_inst_wait", {30'b0, inst_addr_ok, inst_data_ok}, 32'd0);
        tick(); axi_bus.rvalid = 0;
        push_exp(0, 1, 32'h2222_2222);
        #1;
        chk("t3_inst_addr_ok", {30'b0, inst_addr_ok, data_addr_ok}, 32'd2);
        tick(); inst_req = 0; axi_bus.arready = 1;
        #1;
        chk("t3_arid_inst", {28'b0, axi_bus.arid}, 32'd0);
        chk("t3_araddr_inst", axi_bus.araddr, 32'h0000_0200);
        tick(); axi_bus.arready = 0; axi_bus.rvalid = 1; axi_bus.rdata = 32'h2222_2222;
        #1;
        chk("t3_inst_data_ok", {30'b0, inst_data_ok, data_data_ok}, 32'd2);
        tick(); axi_bus.rvalid = 0;

        // Half store, AW and W in the same cycle
        push_exp(1, 0, 32'h0);
        issue_data(1'b1, 2'b01, 32'h0000_2002, 32'h1234_0000);
        tick(); data_req = 0; axi_bus.awready = 1; axi_bus.wready = 1;
        #1;
        chk("t4_wstrb", {28'b0, axi_bus.wstrb}, 32'hC);
        chk("t4_valids", {30'b0, axi_bus.awvalid, axi_bus.wvalid}, 32'd3);
        tick(); axi_bus.awready = 0; axi_bus.wready = 0; axi_bus.bvalid = 1;
        #1;
        chk("t4_wr_resp", {29'b0, axi_bus.awvalid, axi_bus.wvalid, axi_bus.bready}, 32'd1);
        tick(); axi_bus.bvalid = 0;

        // Reset in RD_DATA aborts the read
        issue_data(1'b0, 2'b10, 32'h0000_3000, 32'h0);
        tick(); data_req = 0; axi_bus.arready = 1;
        tick(); axi_bus.arready = 0;
        #1;
        chk("t5_rready_pre", {31'b0, axi_bus.rready}, 32'd1);
        rst = 1;
        tick(); rst = 0; axi_bus.rvalid = 1; axi_bus.rdata = 32'h0000_0BAD;
        #1;
        chk("t5_valids_cleared", {27'b0, axi_bus.arvalid, axi_bus.rready, axi_bus.awvalid,
                                  axi_bus.wvalid, axi_bus.bready}, 32'd0);
        chk("t5_no_data_ok", {31'b0, data_data_ok}, 32'd0);
        tick(); axi_bus.rvalid = 0;

        // Dirty miss: write-back then refill read, strictly ordered
        push_exp(1, 0, 32'h0);
        issue_data(1'b1, 2'b10, 32'h0000_2000, 32'hCAFE_F00D);
        tick(); data_wr = 0; data_addr = 32'h0000_3000; data_wdata = 0;
        axi_bus.awready = 1; axi_bus.wready = 1;
        #1;
        chk("t6_addr_ok_busy", {31'b0, data_addr_ok}, 32'd0);
        chk("t6_aw_w_first", {29'b0, axi_bus.awvalid, axi_bus.wvalid, axi_bus.arvalid}, 32'd6);
        chk("t6_wstrb", {28'b0, axi_bus.wstrb}, 32'hF);
        chk("t6_awaddr", axi_bus.awaddr, 32'h0000_2000);
        tick(); axi_bus.awready = 0; axi_bus.wready = 0; axi_bus.bvalid = 1;
        #1;
        chk("t6_b_then", {29'b0, axi_bus.bready, axi_bus.arvalid, data_addr_ok}, 32'd4);
        tick(); axi_bus.bvalid = 0;
        push_exp(1, 1, 32'h5A5A_5A5A);
        #1;
        chk("t6_read_addr_ok", {30'b0, data_addr_ok, axi_bus.bready}, 32'd2);
        tick(); data_req = 0; axi_bus.arready = 1;
        #1;
        chk("t6_ar_after_b", {31'b0, axi_bus.arvalid}, 32'd1);
        chk("t6_araddr", axi_bus.araddr, 32'h0000_3000);
        tick(); axi_bus.arready = 0; axi_bus.rvalid = 1; axi_bus.rdata = 32'h5A5A_5A5A;
        #1;
        chk("t6_r_data_ok", {31'b0, data_data_ok}, 32'd1);
        tick(); axi_bus.rvalid = 0;

        // Strobe sweep across every size and lane offset
        for (int s = 0; s < 3; s++) begin
            for (int lo = 0; lo < 4; lo++) begin
                logic [1:0] sz;
                logic [1:0] lo2;
                sz  = 2'(s);
                lo2 = 2'(lo);
                push_exp(1, 0, 32'h0);
                issue_data(1'b1, sz, {30'h0000_1100, lo2}, 32'h0102_0304);
                tick(); data_req = 0; axi_bus.awready = 1; axi_bus.wready = 1;
                #1;
                chk("sweep_wstrb", {28'b0, axi_bus.wstrb}, {28'b0, ref_wstrb(sz, lo2)});
                tick(); axi_bus.awready = 0; axi_bus.wready = 0; axi_bus.bvalid = 1;
                tick(); axi_bus.bvalid = 0;
            end
        end

        tick();
        chk("sb_drained", sb_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
